// File: rtl/grant_stream_mux_pkg.sv
// -----------------------------------------------------------------------------
// grant_stream_mux_pkg
//
// Purpose: shared definitions for grant_stream_mux and its grant encoder.
//   - FSM state encoding (2-bit) and the state enum built on it
//   - default stall limit used by the optional timeout
//   - the `SD delay macro used on register updates (expands to nothing, so
//     register updates are zero-delay)
//
// Optional feature macro used by the top: GRANT_STREAM_TIMEOUT_EN
// -----------------------------------------------------------------------------
`ifndef SD
`define SD
`endif

package grant_stream_mux_pkg;

    // Raw 2-bit encodings, kept as named constants so other grant consumers
    // can decode a probed state register without importing the enum.
    localparam logic [1:0] ST_IDLE_ENC    = 2'd0;
    localparam logic [1:0] ST_GRANT_ENC   = 2'd1;
    localparam logic [1:0] ST_XFER_ENC    = 2'd2;
    localparam logic [1:0] ST_RELEASE_ENC = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE    = ST_IDLE_ENC,
        ST_GRANT   = ST_GRANT_ENC,
        ST_XFER    = ST_XFER_ENC,
        ST_RELEASE = ST_RELEASE_ENC
    } state_t;

    // Stall limit in XFER cycles without a handshake before the owner is
    // forcibly released (only meaningful with GRANT_STREAM_TIMEOUT_EN).
    localparam int DEFAULT_TIMEOUT_CYCLES = 255;

endpackage

// File: rtl/grant_stream_mux_onehot_to_index.sv
// -----------------------------------------------------------------------------
// onehot_to_index
//
// Purpose: lowest-set-bit encoder. Turns a (nominally one-hot) grant vector
// into the index of its lowest set bit. A vector with several bits set is not
// an error: the lowest bit simply wins. Purely combinational.
//
// Ports:
//   onehot  in   WIDTH   grant vector
//   index   out  IDX_W   position of the lowest set bit (0 when none set)
//   found   out  1       at least one bit of onehot is set
// -----------------------------------------------------------------------------
module onehot_to_index
    import grant_stream_mux_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int IDX_W = 3
) (
    input  logic [WIDTH-1:0] onehot,
    output logic [IDX_W-1:0] index,
    output logic             found
);

    // lowest[gi] is set only for the lowest set bit of onehot, so at most one
    // bit of it is high and the index can be formed by OR-ing positions.
    logic [WIDTH-1:0] lowest;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_lowest
            if (gi == 0) begin : g_first
                assign lowest[gi] = onehot[gi];
            end else begin : g_rest
                assign lowest[gi] = onehot[gi] & ~(|onehot[gi-1:0]);
            end
        end
    endgenerate

    always_comb begin
        index = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (lowest[i]) begin
                index = index | IDX_W'(i);
            end
        end
    end

    assign found = |onehot;

endmodule

// File: rtl/grant_stream_mux.sv
// -----------------------------------------------------------------------------
// grant_stream_mux
//
// Purpose: consumer of a priority selector's registered one-hot grants. It
// drives the selector's enable/latch so that one requester owns the shared
// output stream for an entire packet, muxes the owner's beats onto the output
// with ready back-propagated to that owner only, and releases ownership by
// latching an all-zero grant once the last beat has been accepted.
//
// Ports:
//   clk, rst       clock; synchronous active-high reset
//   src_data       WIDTH*DATA_W packed payloads, source i at [i*DATA_W +: DATA_W]
//   src_valid      per-source beat valid (also the selector's requests)
//   src_last       per-source last-beat flag
//   src_ready      per-source accept; only the owner's bit can be high
//   sel_requests   to selector: copy of src_valid
//   sel_enable     to selector: arbitrate on the next latch
//   sel_latch      to selector: load grant register
//   sel_grants     from selector: registered grant vector
//   out_data/out_valid/out_last   muxed stream from the owner
//   out_ready      downstream accept
//   out_src        index of the current owner
//   busy           FSM is not in IDLE
//   abort          (GRANT_STREAM_TIMEOUT_EN only) one-cycle pulse when a
//                  stalled owner is forcibly released
//
// Configuration macro: GRANT_STREAM_TIMEOUT_EN enables the stall timeout and
// the abort port. Without it a stalled owner keeps the bus indefinitely.
//
// Timing: request seen in IDLE (latch) -> GRANT (owner captured) -> XFER, so
// the first out_valid appears two cycles after the request. After the last
// handshake, RELEASE latches a zero grant and IDLE follows.
// -----------------------------------------------------------------------------
module grant_stream_mux
    import grant_stream_mux_pkg::*;
#(
    parameter int WIDTH          = 8,
    parameter int DATA_W         = 8,
    parameter int IDX_W          = 3,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [WIDTH*DATA_W-1:0] src_data,
    input  logic [WIDTH-1:0]        src_valid,
    input  logic [WIDTH-1:0]        src_last,
    output logic [WIDTH-1:0]        src_ready,
    output logic [WIDTH-1:0]        sel_requests,
    output logic                    sel_enable,
    output logic                    sel_latch,
    input  logic [WIDTH-1:0]        sel_grants,
    output logic [DATA_W-1:0]       out_data,
    output logic                    out_valid,
    output logic                    out_last,
    input  logic                    out_ready,
    output logic [IDX_W-1:0]        out_src,
    output logic                    busy
`ifdef GRANT_STREAM_TIMEOUT_EN
    ,
    output logic                    abort
`endif
);

    state_t           state_reg;
    logic [IDX_W-1:0] owner_reg;

    logic [IDX_W-1:0] grant_idx;
    logic             grant_any;

    logic             in_idle;
    logic             in_xfer;
    logic             handshake;
    logic             timeout_hit;
    logic             arb_request;

    // Per-source payload view, so the owner mux is a plain array index.
    logic [DATA_W-1:0] data_arr [WIDTH];

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_data_arr
            assign data_arr[gi] = src_data[gi*DATA_W +: DATA_W];
        end
    endgenerate

    onehot_to_index #(
        .WIDTH (WIDTH),
        .IDX_W (IDX_W)
    ) u_grant_enc (
        .onehot (sel_grants),
        .index  (grant_idx),
        .found  (grant_any)
    );

    assign in_idle = (state_reg == ST_IDLE);
    assign in_xfer = (state_reg == ST_XFER);

    // An arbitration request is only raised outside reset so that a source
    // still holding valid while rst is high cannot pulse the selector.
    assign arb_request = in_idle & (|src_valid) & ~rst;

    // ------------------------------------------------------------------
    // Selector controls
    // ------------------------------------------------------------------
    assign sel_requests = src_valid;
    // IDLE: enable+latch arbitrates. RELEASE: latch without enable loads a
    // zero grant. Latch stays low in GRANT/XFER so the grant cannot move
    // while a packet is in flight.
    assign sel_enable   = arb_request;
    assign sel_latch    = arb_request | (state_reg == ST_RELEASE);

    // ------------------------------------------------------------------
    // Output stream mux. The abort cycle (if enabled) is masked so no beat
    // is half-accepted while ownership is being torn down.
    // ------------------------------------------------------------------
    assign out_valid = in_xfer & ~timeout_hit & src_valid[owner_reg];
    assign out_last  = in_xfer & ~timeout_hit & src_last[owner_reg];
    assign out_data  = in_xfer ? data_arr[owner_reg] : '0;
    assign out_src   = owner_reg;
    assign busy      = ~in_idle;
    assign handshake = out_valid & out_ready;

    always_comb begin
        src_ready = '0;
        if (in_xfer && !timeout_hit) begin
            src_ready[owner_reg] = out_ready;
        end
    end

    // ------------------------------------------------------------------
    // Optional stall timeout
    // ------------------------------------------------------------------
`ifdef GRANT_STREAM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] stall_cnt_reg;

    // Counts consecutive XFER cycles without a handshake; reaching the limit
    // forces RELEASE in the following cycle.
    always_ff @(posedge clk) begin
        if (rst || !in_xfer || handshake) begin
            stall_cnt_reg <= `SD '0;
        end else begin
            stall_cnt_reg <= `SD stall_cnt_reg + CNT_W'(1);
        end
    end

    assign timeout_hit = in_xfer && (stall_cnt_reg == CNT_W'(TIMEOUT_CYCLES));
    assign abort       = timeout_hit;
`else
    logic unused_timeout_cfg;

    assign timeout_hit        = 1'b0;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
`endif

    // ------------------------------------------------------------------
    // Ownership FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= `SD ST_IDLE;
            owner_reg <= `SD '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (|src_valid) begin
                        state_reg <= `SD ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    // sel_grants now holds the result of the IDLE latch. A
                    // zero grant means the request vanished before it was
                    // registered; nothing was latched for us to release.
                    owner_reg <= `SD grant_idx;
                    state_reg <= `SD grant_any ? ST_XFER : ST_IDLE;
                end
                ST_XFER: begin
                    // A dropped valid just stalls; only the last handshake
                    // (or a timeout) ends ownership.
                    if ((handshake && out_last) || timeout_hit) begin
                        state_reg <= `SD ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    state_reg <= `SD ST_IDLE;
                end
                default: begin
                    state_reg <= `SD ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_grant_stream_mux.sv
module tb_grant_stream_mux;

    localparam int WIDTH  = 8;
    localparam int DATA_W = 8;
    localparam int IDX_W  = 3;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic [WIDTH*DATA_W-1:0] src_data;
    logic [WIDTH-1:0]        src_valid;
    logic [WIDTH-1:0]        src_last;
    logic [WIDTH-1:0]        src_ready;
    logic [WIDTH-1:0]        sel_requests;
    logic                    sel_enable;
    logic                    sel_latch;
    logic [WIDTH-1:0]        sel_grants;
    logic [DATA_W-1:0]       out_data;
    logic                    out_valid;
    logic                    out_last;
    logic                    out_ready;
    logic [IDX_W-1:0]        out_src;
    logic                    busy;
`ifdef GRANT_STREAM_TIMEOUT_EN
    logic                    abort;
`endif

    always #5 clk = ~clk;

    grant_stream_mux #(
        .WIDTH          (WIDTH),
        .DATA_W         (DATA_W),
        .IDX_W          (IDX_W),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .src_data     (src_data),
        .src_valid    (src_valid),
        .src_last     (src_last),
        .src_ready    (src_ready),
        .sel_requests (sel_requests),
        .sel_enable   (sel_enable),
        .sel_latch    (sel_latch),
        .sel_grants   (sel_grants),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_last     (out_last),
        .out_ready    (out_ready),
        .out_src      (out_src),
        .busy         (busy)
`ifdef GRANT_STREAM_TIMEOUT_EN
        ,
        .abort        (abort)
`endif
    );

    // Priority selector stand-in: on latch, loads the lowest requesting bit
    // when enabled, zero otherwise. stub_zero emulates a selector whose
    // request disappeared before it registered the grant.
    bit stub_zero = 1'b0;
    always @(posedge clk) begin
        if (rst) begin
            sel_grants <= '0;
        end else if (sel_latch) begin
            sel_grants <= (sel_enable && !stub_zero) ?
                          (sel_requests & (~sel_requests + 1'b1)) : '0;
        end
    end

    // Reference model: per-source beat queues. stim_q feeds the source
    // drivers; exp_q is what the output must deliver for each source.
    logic [DATA_W:0] stim_q [WIDTH][$];
    logic [DATA_W:0] exp_q  [WIDTH][$];
    int              pkt_order[$];
    logic [WIDTH-1:0] hold = '0;
    bit              gap_en   = 1'b0;
    bit              rand_rdy = 1'b0;
    bit              rdy_pat[$];
    int              total  = 0;
    int              passed = 0;

    task automatic check(string name, logic [63:0] got, logic [63:0] want);
        total++;
        if (got === want) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
    endtask

    task automatic push_pkt(int s, int n, logic [DATA_W-1:0] base);
        for (int k = 0; k < n; k++) begin
            logic [DATA_W:0] b;
            b = {(k == n - 1), base + DATA_W'(k)};
            stim_q[s].push_back(b);
            exp_q[s].push_back(b);
        end
    endtask

    function automatic bit all_empty();
        for (int i = 0; i < WIDTH; i++)
            if (stim_q[i].size() != 0 || exp_q[i].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic sample();
        @(negedge clk);
        #3;
    endtask

    task automatic wait_drain(int budget);
        int n = 0;
        while ((!all_empty() || busy) && n < budget) begin
            sample();
            n++;
        end
        total++;
        if (n < budget) passed++;
        else $display("FAIL drain_timeout: waited %0d cycles, expected drain within %0d", n, budget);
    endtask

    // Source + downstream driver: drive at negedge, retire accepted beats
    // just before the next posedge.
    logic [DATA_W:0] drv_beat;
    initial begin
        src_valid = '0;
        src_data  = '0;
        src_last  = '0;
        out_ready = 1'b1;
        forever begin
            @(negedge clk);
            for (int i = 0; i < WIDTH; i++) begin
                if (stim_q[i].size() > 0 && !hold[i] &&
                    !(gap_en && $urandom_range(3) == 0)) begin
                    drv_beat = stim_q[i][0];
                    src_valid[i] = 1'b1;
                    src_data[i*DATA_W +: DATA_W] = drv_beat[DATA_W-1:0];
                    src_last[i]  = drv_beat[DATA_W];
                end else begin
                    src_valid[i] = 1'b0;
                    src_last[i]  = 1'b0;
                end
            end
            if (rdy_pat.size() > 0) out_ready = rdy_pat.pop_front();
            else out_ready = rand_rdy ? ($urandom_range(2) != 0) : 1'b1;
            #2;
            for (int i = 0; i < WIDTH; i++)
                if (src_valid[i] && src_ready[i]) void'(stim_q[i].pop_front());
        end
    end

    // Monitor: pops the expected beat of the reported owner on each output
    // handshake and enforces whole-packet ownership.
    bit              in_pkt  = 1'b0;
    int              pkt_src = 0;
    int              mon_src;
    logic [DATA_W:0] mon_beat;
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                in_pkt = 1'b0;
            end else if (out_valid && out_ready) begin
                mon_src = int'(out_src);
                if (exp_q[mon_src].size() == 0) begin
                    total++;
                    $display("FAIL unexpected_beat: src %0d data 0x%0h, expected no beat", mon_src, out_data);
                end else begin
                    mon_beat = exp_q[mon_src].pop_front();
                    $display("beat src=%0d data=0x%0h last=%0b", mon_src, out_data, out_last);
                    check("beat_data", 64'(out_data), 64'(mon_beat[DATA_W-1:0]));
                    check("beat_last", 64'(out_last), 64'(mon_beat[DATA_W]));
                end
                if (in_pkt) begin
                    check("no_interleave", 64'(mon_src), 64'(pkt_src));
                end else begin
                    in_pkt  = 1'b1;
                    pkt_src = mon_src;
                    pkt_order.push_back(mon_src);
                end
                if (out_last) in_pkt = 1'b0;
            end
`ifdef GRANT_STREAM_TIMEOUT_EN
            if (abort) in_pkt = 1'b0;
`endif
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int plen;
        int psrc;
        repeat (3) @(negedge clk);
        #3;
        check("rst_busy",      64'(busy), 0);
        check("rst_out_valid", 64'(out_valid), 0);
        check("rst_sel_latch", 64'(sel_latch), 0);
        check("rst_src_ready", 64'(src_ready), 0);
        check("rst_out_src",   64'(out_src), 0);
        check("rst_out_data",  64'(out_data), 0);
        rst = 1'b0;
        sample();

        // Single source 2, three beats, out_ready held high.
        push_pkt(2, 3, 8'hA1);
        sample();   // cycle 0
        check("t1_c0_latch",  64'(sel_latch), 1);
        check("t1_c0_enable", 64'(sel_enable), 1);
        sample();   // cycle 1
        check("t1_c1_valid", 64'(out_valid), 0);
        check("t1_c1_busy",  64'(busy), 1);
        sample();   // cycle 2
        check("t1_c2_valid", 64'(out_valid), 1);
        check("t1_c2_src",   64'(out_src), 2);
        sample();
        sample();   // cycle 4
        check("t1_c4_last", 64'(out_last), 1);
        sample();   // cycle 5
        check("t1_c5_latch",  64'(sel_latch), 1);
        check("t1_c5_enable", 64'(sel_enable), 0);
        check("t1_c5_valid",  64'(out_valid), 0);
        sample();   // cycle 6
        check("t1_c6_busy", 64'(busy), 0);
        wait_drain(50);

        // Sources 1 and 5 together: 1 wins, 5 follows, no interleaving.
        pkt_order.delete();
        push_pkt(1, 3, 8'h10);
        push_pkt(5, 2, 8'h50);
        wait_drain(100);
        check("t2_pkts",   64'(pkt_order.size()), 2);
        check("t2_first",  64'((pkt_order.size() > 0) ? pkt_order[0] : -1), 1);
        check("t2_second", 64'((pkt_order.size() > 1) ? pkt_order[1] : -1), 5);

        // Backpressure 1,0,0,1 across the first XFER cycles.
        push_pkt(0, 4, 8'h30);
        rdy_pat = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        sample();
        sample();
        for (int k = 0; k < 4; k++) begin
            sample();
            check("t3_ready_mirror", 64'(src_ready[0]), 64'(out_ready));
            check("t3_ready_others", 64'(src_ready[WIDTH-1:1]), 0);
        end
        wait_drain(100);

        // Request withdrawn: latched grant comes back zero.
        stub_zero = 1'b1;
        push_pkt(3, 1, 8'h3C);
        sample();   // cycle 0
        check("t4_c0_latch", 64'(sel_latch), 1);
        hold[3] = 1'b1;
        sample();   // cycle 1 (GRANT)
        check("t4_c1_latch", 64'(sel_latch), 0);
        check("t4_c1_valid", 64'(out_valid), 0);
        sample();   // cycle 2
        check("t4_c2_busy",  64'(busy), 0);
        check("t4_c2_valid", 64'(out_valid), 0);
        check("t4_c2_latch", 64'(sel_latch), 0);
        stim_q[3].delete();
        exp_q[3].delete();
        hold[3]   = 1'b0;
        stub_zero = 1'b0;
        sample();

        // Reset during the second of four beats.
        push_pkt(4, 4, 8'h40);
        repeat (4) sample();   // cycles 0..3, beat 1 accepted in cycle 3
        rst     = 1'b1;
        hold[4] = 1'b1;
        sample();
        check("t5_busy",  64'(busy), 0);
        check("t5_valid", 64'(out_valid), 0);
        check("t5_latch", 64'(sel_latch), 0);
        rst = 1'b0;
        stim_q[4].delete();
        exp_q[4].delete();
        hold[4] = 1'b0;
        pkt_order.delete();
        push_pkt(6, 2, 8'h60);
        wait_drain(100);
        check("t5_after_pkts", 64'(pkt_order.size()), 1);
        check("t5_after_src",  64'((pkt_order.size() > 0) ? pkt_order[0] : -1), 6);

`ifdef GRANT_STREAM_TIMEOUT_EN
        // Owner stalls after its first beat; limit is 4 idle XFER cycles.
        push_pkt(7, 3, 8'h70);
        repeat (3) sample();   // cycle 2 carries beat 0
        hold[7] = 1'b1;
        repeat (4) sample();   // cycles 3..6
        check("to_no_abort_yet", 64'(abort), 0);
        sample();              // cycle 7
        check("to_abort",       64'(abort), 1);
        check("to_abort_ready", 64'(src_ready), 0);
        sample();              // cycle 8
        check("to_rel_latch",  64'(sel_latch), 1);
        check("to_rel_enable", 64'(sel_enable), 0);
        check("to_rel_abort",  64'(abort), 0);
        sample();              // cycle 9
        check("to_idle_busy", 64'(busy), 0);
        stim_q[7].delete();
        exp_q[7].delete();
        hold[7] = 1'b0;
        sample();
`endif

        // Randomized traffic against the per-source queues.
`ifdef GRANT_STREAM_TIMEOUT_EN
        gap_en   = 1'b0;
        rand_rdy = 1'b0;
`else
        gap_en   = 1'b1;
        rand_rdy = 1'b1;
`endif
        pkt_order.delete();
        for (int b = 0; b < 4; b++) begin
            for (int p = 0; p < 10; p++) begin
                psrc = $urandom_range(WIDTH - 1);
                plen = $urandom_range(4, 1);
                push_pkt(psrc, plen, DATA_W'($urandom));
            end
            wait_drain(3000);
        end
        check("rand_pkts", 64'(pkt_order.size()), 40);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
